// File: rtl/ahb3lite_sram1r1w_ctrl.sv
// AHB3-Lite slave front-end for a 1R1W registered-output RAM: zero-wait transfers,
// one-deep write forwarding, and a two-cycle ERROR response for bad size or alignment.
module ahb3lite_sram1r1w_ctrl #(
    parameter int ABITS      = 10,
    parameter int DBITS      = 32,
    parameter int HADDR_SIZE = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [DBITS-1:0]      HWDATA,
    output logic [DBITS-1:0]      HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ABITS-1:0]      ram_waddr_o,
    output logic [DBITS-1:0]      ram_din_o,
    output logic                  ram_we_o,
    output logic [DBITS/8-1:0]    ram_be_o,
    output logic [ABITS-1:0]      ram_raddr_o,
    input  logic [DBITS-1:0]      ram_dout_i
);
    localparam int BEW = DBITS / 8;
    localparam int OFS = $clog2(BEW);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [BEW-1:0]   mask;
        logic             write;
        logic             legal;
    } dph_t;

    state_t           state_q, state_d;
    dph_t             dph_q, dph_d;
    logic             hreadyout_q, hresp_q;
    logic             fwd_vld_q;
    logic [ABITS-1:0] fwd_addr_q;
    logic [DBITS-1:0] fwd_data_q;
    logic [BEW-1:0]   fwd_mask_q;

    logic             accept, legal, fwd_hit;
    logic [OFS-1:0]   boff;
    logic [BEW-1:0]   mask;
    logic             unused;

    assign unused = ^{HBURST, HPROT, HADDR};
    assign accept = HSEL & HREADY & HTRANS[1];
    assign boff   = HADDR[OFS-1:0];

    // Size/alignment legality and little-endian byte lanes of the address phase.
    always_comb begin
        legal = 1'b0;
        mask  = '0;
        if (int'(HSIZE) <= OFS) begin
            legal = (int'(boff) & ((1 << int'(HSIZE)) - 1)) == 0;
            for (int i = 0; i < BEW; i++)
                mask[i] = (i >= int'(boff)) && (i < int'(boff) + (1 << int'(HSIZE)));
        end
    end

    always_comb begin
        dph_d   = dph_q;
        state_d = S_IDLE;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept) begin
            state_d     = legal ? S_DATA : S_ERR1;
            dph_d.addr  = HADDR[ABITS+OFS-1:OFS];
            dph_d.mask  = mask;
            dph_d.write = HWRITE;
            dph_d.legal = legal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            dph_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            fwd_vld_q   <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            fwd_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            dph_q       <= dph_d;
            hreadyout_q <= (state_d != S_ERR1);
            hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            // The RAM reads old data during its own write cycle; hold the write one cycle.
            fwd_vld_q   <= ram_we_o;
            if (ram_we_o) begin
                fwd_addr_q <= dph_q.addr;
                fwd_data_q <= HWDATA;
                fwd_mask_q <= dph_q.mask;
            end
        end
    end

    assign ram_we_o    = (state_q == S_DATA) && dph_q.write && dph_q.legal;
    assign ram_waddr_o = dph_q.addr;
    assign ram_be_o    = dph_q.mask;
    assign ram_din_o   = HWDATA;
    assign ram_raddr_o = HADDR[ABITS+OFS-1:OFS];

    assign fwd_hit = (state_q == S_DATA) && !dph_q.write && fwd_vld_q && (fwd_addr_q == dph_q.addr);

    always_comb begin
        HRDATA = ram_dout_i;
        if (fwd_hit)
            for (int i = 0; i < BEW; i++)
                if (fwd_mask_q[i]) HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram1r1w_ctrl.sv
// Bench for ahb3lite_sram1r1w_ctrl: behavioural RAM, word-level memory model,
// directed vector table, reset-during-write sequence and randomized transfers.
module tb_ahb3lite_sram1r1w_ctrl;
    localparam int ABITS = 10;
    localparam int DBITS = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [2:0]  HBURST = '0;
    logic [3:0]  HPROT = '0;
    logic [1:0]  HTRANS = '0;
    logic        HREADY;
    logic        HREADYOUT, HRESP;
    logic [ABITS-1:0] ram_waddr_o, ram_raddr_o;
    logic [31:0] ram_din_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_dout_i = '0;

    assign HREADY = HREADYOUT;
    always #5 clk_i = ~clk_i;

    ahb3lite_sram1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .HADDR_SIZE(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .ram_waddr_o(ram_waddr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_raddr_o(ram_raddr_o), .ram_dout_i(ram_dout_i)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            8:       return 32'h11223344;
            13:      return 32'h13572468;
            16:      return 32'hCAFEF00D;
            17:      return 32'h76543210;
            18:      return 32'h0BADF00D;
            default: return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Behavioural RAM: registered read, read-before-write, byte enables.
    logic [31:0] mem [1024];
    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk_i);
            rd = mem[ram_raddr_o];
            if (ram_we_o)
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_waddr_o][8*b +: 8] = ram_din_o[8*b +: 8];
            ram_dout_i <= rd;
        end
    end

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        has_exp;
        bit        exp_err;
        bit [3:0]  exp_be;
        bit [31:0] exp_rd;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference: bus-visible memory contents; every read sees all earlier writes.
    logic [31:0] mdl [1024];
    vec_t dp;
    bit   dp_act = 0;
    int   dp_errph = 0;

    function automatic int word_of(input bit [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic bit is_legal(input bit [2:0] size, input bit [31:0] a);
        return (size <= 2) && ((a % (32'd1 << size)) == 0);
    endfunction

    function automatic bit [3:0] lanes(input bit [2:0] size, input bit [31:0] a);
        bit [7:0] m;
        m = 8'((1 << (1 << size)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic vec_t mk(input bit sel, input bit [1:0] trans, input bit wr,
                                input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wd,
                                input bit hx, input bit err, input bit [3:0] be, input bit [31:0] rd);
        vec_t v;
        v.sel = sel; v.trans = trans; v.write = wr; v.size = size; v.addr = addr; v.wdata = wd;
        v.has_exp = hx; v.exp_err = err; v.exp_be = be; v.exp_rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_dp();
        bit err, exp_we;
        int w;
        logic [31:0] m;
        err    = dp_act && (dp_errph != 0);
        exp_we = dp_act && (dp_errph == 0) && dp.write;
        chk("hreadyout", HREADYOUT, {31'd0, !(dp_act && dp_errph == 1)});
        chk("hresp", HRESP, {31'd0, err});
        chk("ram_we", ram_we_o, {31'd0, exp_we});
        if (dp_act && dp.has_exp) chk("tbl_resp", HRESP, {31'd0, dp.exp_err});
        if (dp_act && dp_errph == 0) begin
            w = word_of(dp.addr);
            if (dp.write) begin
                chk("waddr", ram_waddr_o, w);
                chk("be", ram_be_o, lanes(dp.size, dp.addr));
                chk("din", ram_din_o, dp.wdata);
                if (dp.has_exp) chk("tbl_be", ram_be_o, dp.exp_be);
                m = mdl[w];
                for (int b = 0; b < 4; b++)
                    if (lanes(dp.size, dp.addr)[b]) m[8*b +: 8] = dp.wdata[8*b +: 8];
                mdl[w] = m;
            end else begin
                chk("rdata", HRDATA, mdl[w]);
                if (dp.has_exp) chk("tbl_rdata", HRDATA, dp.exp_rd);
            end
        end
    endtask

    // One bus cycle: entered just after a rising edge, returns just after the next one.
    task automatic step(input vec_t nx, output bit taken);
        HSEL = nx.sel; HTRANS = nx.trans; HWRITE = nx.write; HSIZE = nx.size; HADDR = nx.addr;
        HBURST = 3'($urandom); HPROT = 4'($urandom);
        HWDATA = (dp_act && dp.write) ? dp.wdata : $urandom;
        @(negedge clk_i);
        check_dp();
        taken = !(dp_act && dp_errph == 1);
        @(posedge clk_i);
        #1;
        if (dp_act && dp_errph == 1) dp_errph = 2;
        else if (nx.sel && nx.trans[1]) begin
            dp = nx; dp_act = 1; dp_errph = is_legal(nx.size, nx.addr) ? 0 : 1;
        end else dp_act = 0;
    endtask

    task automatic send(input vec_t v);
        bit t;
        int g = 0;
        do begin step(v, t); g++; end while (!t && g < 4);
        chk("accept_bound", {31'd0, t}, 32'd1);
    endtask

    vec_t tbl[$];
    vec_t idle_v;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = init_val(i);
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1, 2, 1, 2, 32'h10, 32'hDEADBEEF, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h10, 0,            1, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2, 1, 0, 32'h23, 32'hAA000000, 1, 0, 4'b1000, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h20, 0,            1, 0, 0, 32'hAA223344));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0,            1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h20, 0,            1, 0, 0, 32'hAA223344));
        tbl.push_back(mk(1, 2, 1, 2, 32'h30, 32'h55555555, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h34, 0,            1, 0, 0, 32'h13572468));
        tbl.push_back(mk(1, 2, 1, 1, 32'h41, 32'h12345678, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h40, 0,            1, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(1, 2, 1, 3, 32'h48, 32'h99999999, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 2, 32'h48, 32'h77777777, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2, 32'h48, 32'h66666666, 1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 2, 32'h48, 32'h44444444, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 2, 32'h48, 0,            1, 0, 0, 32'h0BADF00D));
        tbl.push_back(mk(1, 2, 1, 1, 32'h46, 32'hBEEF0000, 1, 0, 4'b1100, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h44, 0,            1, 0, 0, 32'hBEEF3210));
        tbl.push_back(mk(1, 2, 0, 2, 32'h4A, 0,            1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 2, 32'h1020, 0,          1, 0, 0, 32'hAA223344));

        #1 rst_ni = 1'b0;
        #2;
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_we", ram_we_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_hold_we", ram_we_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        foreach (tbl[i]) send(tbl[i]);
        for (int i = 0; i < 3; i++) send(idle_v);

        // Reset asserted during the data phase of a write: the write must not land.
        send(mk(1, 2, 1, 2, 32'h50, 32'h12345678, 0, 0, 0, 0));
        HSEL = 0; HTRANS = 0; HWDATA = 32'h12345678;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_we", ram_we_o, 0);
        chk("midrst_hreadyout", HREADYOUT, 1);
        chk("midrst_hresp", HRESP, 0);
        dp_act = 0; dp_errph = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send(mk(1, 2, 0, 2, 32'h50, 0, 1, 0, 0, init_val(20)));
        send(idle_v);

        for (int n = 0; n < 400; n++) begin
            vec_t v;
            int r;
            r = $urandom_range(0, 9);
            v.size  = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
            v.addr  = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 4) != 0 && v.size <= 2) v.addr = v.addr & ~((32'd1 << v.size) - 1);
            r = $urandom_range(0, 5);
            v.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'(2 + (r & 1));
            v.sel   = ($urandom_range(0, 7) != 0);
            v.write = $urandom_range(0, 1) == 1;
            v.wdata = $urandom;
            v.has_exp = 0; v.exp_err = 0; v.exp_be = 0; v.exp_rd = 0;
            send(v);
        end
        for (int i = 0; i < 3; i++) send(idle_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram1r1w_ctrl.md
Name: ahb3lite_sram1r1w_ctrl

Overview:
- AHB3-Lite slave front-end that sits directly upstream of the team's generic 1R1W inferrable RAM.
- Converts AHB address/data-phase transfers into RAM write-port (address, data, write-enable, byte-enable) and read-port (address) signals, and returns the RAM's registered read data on HRDATA.
- Zero wait states for legal transfers.
- Includes a one-deep write-forwarding buffer, because the RAM has no read-during-write bypass.
- Returns the AHB two-cycle ERROR response for illegal transfer sizes and misaligned addresses.

Parameters:
- ABITS, 10, RAM word-address width; must match the RAM instance.
- DBITS, 32, data width; legal values 32 or 64. OFS = log2(DBITS/8).
- HADDR_SIZE, 32, AHB address width.

Ports:
- clk_i  in  1  clock, rising edge; also HCLK
- rst_ni  in  1  reset, asynchronous, active low
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWDATA  in  DBITS  write data, data phase
- HRDATA  out  DBITS  read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  ignored; each beat handled independently
- HPROT  in  4  ignored
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HREADY  in  1  bus-ready (muxed)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- ram_waddr_o  out  ABITS  RAM write address
- ram_din_o  out  DBITS  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DBITS/8  RAM byte enables
- ram_raddr_o  out  ABITS  RAM read address
- ram_dout_i  in  DBITS  RAM read data; registered in the RAM, 1-cycle latency

Behaviour:
- Address phase is accepted when HSEL & HREADY & HTRANS[1].
  - IDLE/BUSY, or HSEL=0: OKAY, zero-wait; no RAM write.
- Legality check at acceptance:
  - Legal requires HSIZE <= OFS and HADDR[OFS-1:0] a multiple of 2^HSIZE.
  - Otherwise the transfer is illegal.
- Byte mask, little-endian: bits [HADDR[OFS-1:0] +: 2^HSIZE] set.
- Word address = HADDR[ABITS+OFS-1:OFS]. Upper address bits are ignored (aliasing).
- Registered on acceptance: word address, byte mask, write flag, legal flag.
- Reset values (async): HREADYOUT=1, HRESP=0, ram_we_o=0, all data-phase registers 0, forward-buffer valid=0, FSM=IDLE. HRDATA follows ram_dout_i after reset.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE or DATA → DATA on a legal acceptance.
  - IDLE or DATA → ERR1 on an illegal acceptance.
  - Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=1. In ERR2, HREADY=1, so a new acceptance is possible: → DATA/ERR1/IDLE as from IDLE.
  - All other states: HREADYOUT=1, HRESP=0.
- Write, state DATA with registered write flag:
  - ram_we_o=1 combinationally; ram_waddr_o = registered address; ram_be_o = registered mask.
  - ram_din_o = HWDATA; the RAM commits on the clock edge ending the data phase.
  - ram_we_o=0 in every other state. An illegal write never writes RAM.
- Read:
  - ram_raddr_o = HADDR word address every cycle (combinational).
  - The RAM returns the data one cycle later, aligned with the read data phase.
  - HRDATA = ram_dout_i, forwarded per byte (below). HRDATA is don't-care outside a read data phase.
- Forward buffer (write-forwarding):
  - Loaded on every write commit: address, HWDATA, mask; valid=1.
  - Valid clears on the next clock unless reloaded.
  - In a read data phase with valid=1 and a matching word address: each byte with mask bit set takes the buffered byte; all other bytes take ram_dout_i.
  - Covers write@N followed by read@N+1 to the same word.
- Back-to-back: write, read, and write transfers are sustained at one per cycle with no stalls.
- Reset mid-transfer: returns everything to reset values immediately; no pending write completes.
- Throughput: one transfer per cycle. Read latency = 1 data-phase cycle; write visible to the next transfer via forwarding.

Test Plan:
- Word write/read: NONSEQ write 0x0000_0010, HWDATA=0xDEADBEEF, then NONSEQ read 0x10 -> ram_we_o=1, ram_be_o=4'b1111 for one cycle; read returns 0xDEADBEEF; HREADYOUT=1, HRESP=0 throughout.
- Byte lanes: word 0x20 preset to 0x11223344; byte write 0x23 with HWDATA=0xAA000000, then read 0x20 in the next cycle -> ram_be_o=4'b1000; HRDATA=0xAA223344 (forwarded); a later non-adjacent read also returns 0xAA223344.
- Forwarding miss: write 0x30=0x55555555, then read 0x34 -> HRDATA = RAM contents of 0x34; no forwarding.
- Misaligned: halfword write at 0x41 -> HREADYOUT 0 then 1 with HRESP=1 for two cycles; ram_we_o stays 0; a following legal read of 0x40 completes OKAY.
- Oversize: HSIZE=3 with DBITS=32 -> ERROR sequence. HTRANS=IDLE or BUSY with HSEL=1 -> OKAY, no write.
- Reset mid-write: assert rst_ni=0 during a write data phase -> ram_we_o=0 and HREADYOUT=1 immediately; target word unchanged after reset release.
